pulse_burst_ctrl: RTL



---
 rtl/pulse_burst_if.sv | 29 ++
 rtl/pulse_burst_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_if.sv
// Control/status bundle between the Control register bank and the pulse burst sequencer.
// The master side drives the controls; the slave side returns pulse and status.
interface pulse_burst_if #(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
);
    logic               start;
    logic               trig;
    logic               use_trig;
    logic               abort;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   width;
    logic [BURST_W-1:0] count;
    logic               pulse;
    logic               busy;
    logic               armed;
    logic               done;
    logic [BURST_W-1:0] pulse_idx;

    modport master (
        output start, trig, use_trig, abort, period, width, count,
        input  pulse, busy, armed, done, pulse_idx
    );

    modport slave (
        input  start, trig, use_trig, abort, period, width, count,
        output pulse, busy, armed, done, pulse_idx
    );
endinterface

// File: rtl/pulse_burst_ctrl.sv
// Run-time pulse burst sequencer: latches period/width/count on a start edge and emits a gated
// pulse train, optionally armed on an external trigger edge, with abort and busy/done status.
module pulse_burst_ctrl #(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    pulse_burst_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic               start_q_r, trig_q_r;
    logic               start_re_s, trig_re_s;
    logic [CNT_W-1:0]   p_r, w_r, ph_r;
    logic [CNT_W-1:0]   p_clamp_s, w_min_s, w_clamp_s, p_use_s, w_use_s, ph_nxt_s;
    logic [BURST_W-1:0] cnt_r, idx_r, cnt_use_s, idx_nxt_s;
    logic               load_s, wrap_s, last_wrap_s;
    logic               pulse_r, busy_r, armed_r, done_r;
    logic               pulse_nxt_s, busy_nxt_s, armed_nxt_s, done_nxt_s;

    assign start_re_s  = bus.start & ~start_q_r;
    assign trig_re_s   = bus.trig & ~trig_q_r;
    assign load_s      = (state_r == ST_IDLE) & start_re_s & ~bus.abort;
    assign wrap_s      = (state_r == ST_RUN) & (ph_r == (p_r - CNT_W'(1)));
    assign last_wrap_s = wrap_s & (cnt_r != {BURST_W{1'b0}}) & (idx_r == (cnt_r - BURST_W'(1)));

    // On the loading cycle the shadows are not yet written, so look through to the clamped inputs.
    assign p_use_s   = load_s ? p_clamp_s : p_r;
    assign w_use_s   = load_s ? w_clamp_s : w_r;
    assign cnt_use_s = load_s ? bus.count : cnt_r;

    // Clamp the requested period and width so every period has a high and a low cycle.
    always_comb begin
        if (bus.period < CNT_W'(2)) begin
            p_clamp_s = CNT_W'(2);
        end else begin
            p_clamp_s = bus.period;
        end
        if (bus.width == {CNT_W{1'b0}}) begin
            w_min_s = CNT_W'(1);
        end else begin
            w_min_s = bus.width;
        end
        if (w_min_s > (p_clamp_s - CNT_W'(1))) begin
            w_clamp_s = p_clamp_s - CNT_W'(1);
        end else begin
            w_clamp_s = w_min_s;
        end
    end

    // Edge-detect history and shadow registers for the burst parameters.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q_r <= 1'b0;
            trig_q_r  <= 1'b0;
            p_r       <= CNT_W'(2);
            w_r       <= CNT_W'(1);
            cnt_r     <= {BURST_W{1'b0}};
        end else begin
            start_q_r <= bus.start;
            trig_q_r  <= bus.trig;
            if (load_s) begin
                p_r   <= p_clamp_s;
                w_r   <= w_clamp_s;
                cnt_r <= bus.count;
            end else begin
                p_r   <= p_r;
                w_r   <= w_r;
                cnt_r <= cnt_r;
            end
        end
    end

    // State register, with the phase/index counters and the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ph_r    <= {CNT_W{1'b0}};
            idx_r   <= {BURST_W{1'b0}};
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
            armed_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ph_r    <= ph_nxt_s;
            idx_r   <= idx_nxt_s;
            pulse_r <= pulse_nxt_s;
            busy_r  <= busy_nxt_s;
            armed_r <= armed_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_re_s) begin
                        state_nxt_s = bus.use_trig ? ST_ARMED : ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (trig_re_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_RUN: begin
                    if (last_wrap_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output logic: the values the registered outputs take in the next cycle.
    always_comb begin
        ph_nxt_s  = {CNT_W{1'b0}};
        idx_nxt_s = {BURST_W{1'b0}};
        if ((state_nxt_s == ST_RUN) && (state_r == ST_RUN)) begin
            if (wrap_s) begin
                ph_nxt_s  = {CNT_W{1'b0}};
                idx_nxt_s = idx_r + BURST_W'(1);
            end else begin
                ph_nxt_s  = ph_r + CNT_W'(1);
                idx_nxt_s = idx_r;
            end
        end else begin
            ph_nxt_s  = {CNT_W{1'b0}};
            idx_nxt_s = {BURST_W{1'b0}};
        end
        pulse_nxt_s = (state_nxt_s == ST_RUN) && (ph_nxt_s < w_use_s);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        armed_nxt_s = (state_nxt_s == ST_ARMED);
        done_nxt_s  = (state_nxt_s == ST_RUN) && (cnt_use_s != {BURST_W{1'b0}}) &&
                      (ph_nxt_s == (p_use_s - CNT_W'(1))) &&
                      (idx_nxt_s == (cnt_use_s - BURST_W'(1)));
    end

    // An abort arriving in the final cycle of a burst suppresses the completion strobe.
    assign bus.done      = done_r & ~bus.abort;
    assign bus.pulse     = pulse_r;
    assign bus.busy      = busy_r;
    assign bus.armed     = armed_r;
    assign bus.pulse_idx = idx_r;
endmodule
